// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INCR              = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit boundary bundle: control/redirect in, PC/ROM address/status out.
interface fetch_pc_unit_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  i_stall;
    logic                  i_halt;
    logic                  i_redirect;
    logic [XLEN-1:0]       i_target;
    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic [XLEN-1:0]       o_pc;
    logic [XLEN-1:0]       o_pc_plus4;
    logic                  o_valid;
    logic                  o_oob;
    logic                  o_trap;
    logic [XLEN-1:0]       o_instret;

    modport master (
        output i_stall, i_halt, i_redirect, i_target,
        input  o_imem_addr, o_pc, o_pc_plus4, o_valid, o_oob, o_trap, o_instret
    );

    modport slave (
        input  i_stall, i_halt, i_redirect, i_target,
        output o_imem_addr, o_pc, o_pc_plus4, o_valid, o_oob, o_trap, o_instret
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: halt > redirect > stall > pc+4.
// With FETCH_MISALIGN_TRAP_EN the redirect target passes unmasked.
module fetch_next_pc import fetch_pkg::*; #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            halt_i,
    input  logic            redirect_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] target_eff;

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned targets are kept so the trapped PC shows the offending address.
    assign target_eff = target_i;
`else
    assign target_eff = target_i & ~XLEN'(3);
`endif

    assign pc_plus4_o = pc_i + XLEN'(PC_INCR);

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (halt_i) begin
            next_pc_o = pc_i;
        end else if (redirect_i) begin
            next_pc_o = target_eff;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, BOOT/RUN/HALT sequencing, retired-instruction counter.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit import fetch_pkg::*; #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     ADDR_WIDTH   = 8,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
    input logic             i_clk,
    input logic             i_rst,
    fetch_pc_unit_if.slave  fetch_io
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic [XLEN-1:0] next_pc, pc_plus4;
    logic            retire;

    fetch_next_pc #(
        .XLEN(XLEN)
    ) u_next_pc (
        .pc_i      (pc_q),
        .halt_i    (fetch_io.i_halt),
        .redirect_i(fetch_io.i_redirect),
        .stall_i   (fetch_io.i_stall),
        .target_i  (fetch_io.i_target),
        .pc_plus4_o(pc_plus4),
        .next_pc_o (next_pc)
    );

    assign retire = fetch_io.i_halt | fetch_io.i_redirect | ~fetch_io.i_stall;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic misaligned;

    assign misaligned = fetch_io.i_redirect & (fetch_io.i_target[1:0] != 2'b00);
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d    = trap_q;
`endif
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                pc_d = next_pc;
                if (retire) begin
                    instret_d = instret_q + XLEN'(1);
                end
                if (fetch_io.i_halt) begin
                    state_d = S_HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
                end else if (misaligned) begin
                    trap_d  = 1'b1;
                    state_d = S_HALT;
`endif
                end
            end
            S_HALT: ;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_VECTOR;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign fetch_io.o_trap = trap_q;
`else
    assign fetch_io.o_trap = 1'b0;
`endif

    assign fetch_io.o_pc        = pc_q;
    assign fetch_io.o_pc_plus4  = pc_plus4;
    assign fetch_io.o_imem_addr = pc_q[ADDR_WIDTH+1:2];
    assign fetch_io.o_oob       = pc_q[XLEN-1:ADDR_WIDTH+2] != '0;
    assign fetch_io.o_valid     = state_q == S_RUN;
    assign fetch_io.o_instret   = instret_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit against a behavioural model; two instances
// (reset vector 0 and 0xFFFF_FFFC) share every input.
module tb_fetch_pc_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif
    localparam logic [31:0] Rv1 = 32'h0000_0000;
    localparam logic [31:0] Rv2 = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        bit          booting;
        bit          halted;
        bit          trap;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    model_t m1, m2;

    fetch_pc_unit_if #(.XLEN(32), .ADDR_WIDTH(8)) bus1 ();
    fetch_pc_unit_if #(.XLEN(32), .ADDR_WIDTH(8)) bus2 ();

    assign bus2.i_stall    = bus1.i_stall;
    assign bus2.i_halt     = bus1.i_halt;
    assign bus2.i_redirect = bus1.i_redirect;
    assign bus2.i_target   = bus1.i_target;

    fetch_pc_unit #(.XLEN(32), .ADDR_WIDTH(8), .RESET_VECTOR(Rv1)) dut1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .fetch_io(bus1.slave)
    );

    fetch_pc_unit #(.XLEN(32), .ADDR_WIDTH(8), .RESET_VECTOR(Rv2)) dut2 (
        .i_clk   (clk),
        .i_rst   (rst),
        .fetch_io(bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic model_t model_next(model_t m, logic [31:0] rv, bit r, bit stall, bit halt,
                                          bit redir, logic [31:0] tgt);
        model_t n = m;
        if (r) begin
            n.pc = rv; n.instret = 0; n.booting = 1; n.halted = 0; n.trap = 0;
        end else if (m.booting) begin
            n.booting = 0;
        end else if (!m.halted) begin
            if (halt || redir || !stall) n.instret = m.instret + 1;
            if (halt) begin
                n.halted = 1;
            end else if (redir) begin
                if (TrapEn && (tgt % 4 != 0)) begin
                    n.pc = tgt; n.trap = 1; n.halted = 1;
                end else begin
                    n.pc = tgt - (tgt % 4);
                end
            end else if (!stall) begin
                n.pc = m.pc + 4;
            end
        end
        return n;
    endfunction

    task automatic check_all();
        logic [63:0] lim;
        lim = 64'd4 * 64'd256;
        check_eq("valid",    {63'd0, bus1.o_valid}, {63'd0, !m1.booting && !m1.halted});
        check_eq("pc",       {32'd0, bus1.o_pc}, {32'd0, m1.pc});
        check_eq("pc_plus4", {32'd0, bus1.o_pc_plus4}, {32'd0, m1.pc + 32'd4});
        check_eq("imem",     {56'd0, bus1.o_imem_addr}, {32'd0, (m1.pc / 4) % 256});
        check_eq("oob",      {63'd0, bus1.o_oob}, {63'd0, {32'd0, m1.pc} >= lim});
        check_eq("trap",     {63'd0, bus1.o_trap}, {63'd0, m1.trap});
        check_eq("instret",  {32'd0, bus1.o_instret}, {32'd0, m1.instret});
        check_eq("rv2_valid", {63'd0, bus2.o_valid}, {63'd0, !m2.booting && !m2.halted});
        check_eq("rv2_pc",   {32'd0, bus2.o_pc}, {32'd0, m2.pc});
        check_eq("rv2_oob",  {63'd0, bus2.o_oob}, {63'd0, {32'd0, m2.pc} >= lim});
        check_eq("rv2_instret", {32'd0, bus2.o_instret}, {32'd0, m2.instret});
    endtask

    task automatic tick(input bit r, input bit stall, input bit halt, input bit redir,
                        input logic [31:0] tgt);
        rst             = r;
        bus1.i_stall    = stall;
        bus1.i_halt     = halt;
        bus1.i_redirect = redir;
        bus1.i_target   = tgt;
        m1 = model_next(m1, Rv1, r, stall, halt, redir, tgt);
        m2 = model_next(m2, Rv2, r, stall, halt, redir, tgt);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] tgt;
        bus1.i_stall = 0; bus1.i_halt = 0; bus1.i_redirect = 0; bus1.i_target = 0;
        m1 = '{pc: 0, instret: 0, booting: 1, halted: 0, trap: 0};
        m2 = m1;
        @(negedge clk);

        // Reset, boot, free run
        tick(1, 0, 0, 0, 0);
        check_eq("boot_valid", {63'd0, bus1.o_valid}, 64'd0);
        check_eq("boot_pc", {32'd0, bus1.o_pc}, 64'd0);
        tick(0, 0, 0, 0, 0);
        check_eq("rv2_first_pc", {32'd0, bus2.o_pc}, 64'hFFFF_FFFC);
        tick(0, 0, 0, 0, 0);
        check_eq("rv2_wrap_pc", {32'd0, bus2.o_pc}, 64'd0);
        tick(0, 0, 0, 0, 0);
        check_eq("run_pc8", {32'd0, bus1.o_pc}, 64'h8);
        check_eq("run_imem2", {56'd0, bus1.o_imem_addr}, 64'd2);
        check_eq("run_instret2", {32'd0, bus1.o_instret}, 64'd2);

        // Stall then release
        repeat (3) tick(0, 1, 0, 0, 0);
        check_eq("stall_pc", {32'd0, bus1.o_pc}, 64'h8);
        tick(0, 0, 0, 0, 0);
        check_eq("release_pc", {32'd0, bus1.o_pc}, 64'hC);

        // Redirect beats stall
        tick(0, 1, 0, 1, 32'h40);
        check_eq("redir_pc", {32'd0, bus1.o_pc}, 64'h40);
        check_eq("redir_imem", {56'd0, bus1.o_imem_addr}, 64'h10);
        check_eq("redir_instret", {32'd0, bus1.o_instret}, 64'd4);

        // Past end of ROM
        tick(0, 0, 0, 1, 32'h3FC);
        tick(0, 0, 0, 0, 0);
        check_eq("oob_flag", {63'd0, bus1.o_oob}, 64'd1);
        check_eq("oob_imem", {56'd0, bus1.o_imem_addr}, 64'd0);

        // Halt freezes everything until reset
        tick(0, 0, 0, 1, 32'h20);
        tick(0, 0, 1, 0, 0);
        check_eq("halt_valid", {63'd0, bus1.o_valid}, 64'd0);
        tick(0, 0, 0, 1, 32'h80);
        check_eq("halt_pc", {32'd0, bus1.o_pc}, 64'h20);
        tick(1, 0, 0, 0, 0);
        check_eq("rst_pc", {32'd0, bus1.o_pc}, 64'd0);

        // Misaligned redirect
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h42);
        check_eq("mis_pc", {32'd0, bus1.o_pc}, TrapEn ? 64'h42 : 64'h40);
        check_eq("mis_trap", {63'd0, bus1.o_trap}, {63'd0, TrapEn});
        check_eq("mis_valid", {63'd0, bus1.o_valid}, {63'd0, !TrapEn});

        // Randomized run
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: tgt = $urandom & 32'h0000_07FC;
                1: tgt = $urandom;
                2: tgt = 32'h0000_03F0 | ($urandom & 32'hF);
                default: tgt = 32'hFFFF_FF00 | ($urandom & 32'hFC);
            endcase
            tick($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end of the single-cycle core, directly upstream of the instruction ROM.
- Holds the program counter and selects the next PC (sequential or redirect).
- Drives the ROM word address and supplies PC/PC+4 to the execute datapath.
- Sequences boot, run and halt with a small FSM; counts retired instructions.

Parameters:
- XLEN, 32, PC / data width in bits
- ADDR_WIDTH, 8, instruction ROM word-address width (2**ADDR_WIDTH words)
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  synchronous, active-high reset
- i_stall  input  1  hold PC this cycle
- i_halt  input  1  enter HALT at next edge (e.g. ECALL/EBREAK decoded)
- i_redirect  input  1  taken branch/JAL/JALR this cycle
- i_target  input  XLEN  redirect byte address
- o_imem_addr  output  ADDR_WIDTH  word address to ROM = pc[ADDR_WIDTH+1:2]
- o_pc  output  XLEN  current PC
- o_pc_plus4  output  XLEN  pc+4 (link value)
- o_valid  output  1  current instruction is architecturally valid
- o_oob  output  1  pc >= 4*2**ADDR_WIDTH (outside ROM)
- o_trap  output  1  misaligned-target trap latched (see Optional Feature)
- o_instret  output  XLEN  retired-instruction counter

Behaviour:
- Reset (i_rst=1 at edge): pc<=RESET_VECTOR, state<=S_BOOT, o_instret<=0, o_trap<=0. Reset wins over every other input, in any state.
- o_imem_addr, o_pc, o_pc_plus4 and o_oob are combinational from the pc register. o_valid is combinational from state.
- FSM states: S_BOOT, S_RUN, S_HALT.
- S_BOOT: one cycle, o_valid=0, pc held, redirect/stall/halt ignored; next state S_RUN. First valid instruction appears 2 cycles after reset deasserts edge (i.e. cycle after BOOT).
- S_RUN: o_valid=1.
  - Next-PC priority: i_halt > i_redirect > i_stall > pc+4.
  - i_halt=1: pc held, state<=S_HALT; the current instruction retires.
  - i_redirect=1: pc<=aligned target; applies even if i_stall=1 (redirect flushes stall).
  - i_stall=1 alone: pc held, no retire.
  - Otherwise: pc<=pc+4.
- Arithmetic: pc+4 is modulo 2**XLEN; 32'hFFFF_FFFC wraps to 0.
- ROM addressing wraps: o_imem_addr drops the upper bits. o_oob flags the condition but does not stop fetch.
- o_instret increments by 1 (mod 2**XLEN) on each S_RUN edge where i_stall=0 or i_redirect=1 or i_halt=1.
- S_HALT: o_valid=0, pc and o_instret frozen, all inputs except i_rst ignored; exit only via reset.
- Alignment without the feature: target[1:0] forced to 2'b00.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined: in S_RUN with i_redirect=1 and i_target[1:0]!=0 (and i_halt=0):
  - pc<=i_target unmodified, o_trap<=1, state<=S_HALT.
  - o_trap stays 1 until reset.
  - The redirecting instruction retires.
- Undefined: target low bits masked to 0, o_trap tied to 0, no trap path in the FSM.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum (S_BOOT, S_RUN, S_HALT)
  - PC_INCR=4
  - default RESET_VECTOR constant
- One sub-module is natural: fetch_next_pc, the combinational next-PC/priority mux (halt/redirect/stall/increment plus alignment). FSM, PC register and counter stay in the top.

Test Plan:
- Reset then 4 free-running cycles -> BOOT cycle o_valid=0, o_pc=0. Then o_pc 0,4,8 with o_imem_addr 0,1,2 and o_instret 0,1,2.
- i_stall=1 for 3 cycles at pc=0x8 -> o_pc stays 0x8, o_instret constant. Release -> 0xC.
- i_redirect=1, i_target=0x40 with i_stall=1 -> next o_pc=0x40, o_imem_addr=0x10, o_instret+1.
- Run to pc=0x3FC (ADDR_WIDTH=8) -> next pc 0x400, o_oob=1, o_imem_addr=0. Also RESET_VECTOR=32'hFFFF_FFFC -> wraps to 0.
- i_halt=1 at pc=0x20 -> o_valid=0 next cycle, pc frozen at 0x20, redirects ignored. i_rst=1 -> pc=RESET_VECTOR, S_BOOT.
- Redirect to 0x42:
  - with FETCH_MISALIGN_TRAP_EN -> o_trap=1, o_pc=0x42, HALT.
  - without -> o_pc=0x40, o_trap=0, keeps running.
